// File: rtl/mmo_pio_bank.sv
// mmo_pio_bank: synchronised, debounced input bank with edge capture,
// masked irq, event counter and byte-writable outputs on the mmo bus.
module mmo_pio_bank #(
  parameter int IN_WIDTH   = 5,
  parameter int OUT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int DEB_CYCLES = 50000,
  parameter int DEB_WIDTH  = 16
) (
  input  logic                  clk_clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] mmo_address,
  input  logic [31:0]           mmo_writedata,
  input  logic [3:0]            mmo_byteenable,
  input  logic                  mmo_read,
  input  logic                  mmo_write,
  output logic [31:0]           mmo_readdata,
  input  logic [IN_WIDTH-1:0]   pio_in,
  output logic [OUT_WIDTH-1:0]  pio_out,
  output logic                  irq
);

  localparam logic [ADDR_WIDTH-1:0] A_DATA = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_RAW  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_EDGE = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_CAP  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_MASK = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_OUT  = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] A_CNT  = ADDR_WIDTH'(6);
  localparam logic [ADDR_WIDTH-1:0] A_ID   = ADDR_WIDTH'(7);

  localparam logic [DEB_WIDTH-1:0] DEB_MAX =
    DEB_WIDTH'(DEB_CYCLES - 1);
  localparam logic [31:0] IN_VALID =
    32'((64'd1 << IN_WIDTH) - 64'd1);
  localparam logic [31:0] OUT_VALID =
    32'((64'd1 << OUT_WIDTH) - 64'd1);
  localparam logic [31:0] EDGE_VALID =
    IN_VALID | (IN_VALID << 16);
  localparam logic [31:0] ID_WORD =
    {8'hA5, 8'(IN_WIDTH), 8'(OUT_WIDTH), 8'h01};

  logic [IN_WIDTH-1:0] sync1_q, sync2_q;
  logic [IN_WIDTH-1:0] deb_q, deb_d;
  logic [IN_WIDTH-1:0] debdly_q;
  logic [IN_WIDTH-1:0][DEB_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0] edge_q, edge_d;
  logic [IN_WIDTH-1:0] cap_q, cap_d;
  logic [IN_WIDTH-1:0] imask_q, imask_d;
  logic [31:0] out_q, out_d;
  logic [31:0] evcnt_q, evcnt_d;
  logic irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] wmask;
  logic [31:0] wdm;
  logic [31:0] rmux;
  logic [IN_WIDTH-1:0] rise, fall, ev;
  logic ev_any;
  logic we_edge, we_cap, we_mask, we_out, we_cnt;

  assign wmask = {{8{mmo_byteenable[3]}}, {8{mmo_byteenable[2]}},
                  {8{mmo_byteenable[1]}}, {8{mmo_byteenable[0]}}};
  assign wdm   = mmo_writedata & wmask;

  assign we_edge = mmo_write && (mmo_address == A_EDGE);
  assign we_cap  = mmo_write && (mmo_address == A_CAP);
  assign we_mask = mmo_write && (mmo_address == A_MASK);
  assign we_out  = mmo_write && (mmo_address == A_OUT);
  assign we_cnt  = mmo_write && (mmo_address == A_CNT) &&
                   (|mmo_byteenable);

  assign rise   = deb_q & ~debdly_q;
  assign fall   = ~deb_q & debdly_q;
  assign ev     = (rise & edge_q[IN_WIDTH-1:0]) |
                  (fall & edge_q[16 +: IN_WIDTH]);
  assign ev_any = |ev;

  // A change is accepted only after DEB_CYCLES consecutive mismatches.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_MAX) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DEB_WIDTH'(1);
      end
    end
  end

  always_comb begin
    edge_d  = edge_q;
    imask_d = imask_q;
    out_d   = out_q;
    if (we_edge)
      edge_d = ((edge_q & ~wmask) | wdm) & EDGE_VALID;
    if (we_mask)
      imask_d = (imask_q & ~wmask[IN_WIDTH-1:0]) |
                wdm[IN_WIDTH-1:0];
    if (we_out)
      out_d = ((out_q & ~wmask) | wdm) & OUT_VALID;
  end

  // Set beats clear: the event term is OR-ed in after the W1C.
  always_comb begin
    cap_d = cap_q;
    if (we_cap)
      cap_d = cap_q & ~wdm[IN_WIDTH-1:0];
    cap_d = cap_d | ev;
    irq_d = |(cap_d & imask_q);
  end

  always_comb begin
    evcnt_d = evcnt_q + 32'(ev_any);
    if (we_cnt)
      evcnt_d = 32'(ev_any);
  end

  always_comb begin
    rmux = '0;
    case (mmo_address)
      A_DATA:  rmux = 32'(deb_q);
      A_RAW:   rmux = 32'(sync2_q);
      A_EDGE:  rmux = edge_q;
      A_CAP:   rmux = 32'(cap_q);
      A_MASK:  rmux = 32'(imask_q);
      A_OUT:   rmux = out_q;
      A_CNT:   rmux = evcnt_q;
      A_ID:    rmux = ID_WORD;
      default: rmux = '0;
    endcase
    rdata_d = mmo_read ? rmux : 32'h0;
  end

  always_ff @(posedge clk_clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      debdly_q <= '0;
      cnt_q    <= '0;
      edge_q   <= '0;
      cap_q    <= '0;
      imask_q  <= '0;
      out_q    <= '0;
      evcnt_q  <= '0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      sync1_q  <= pio_in;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      debdly_q <= deb_q;
      cnt_q    <= cnt_d;
      edge_q   <= edge_d;
      cap_q    <= cap_d;
      imask_q  <= imask_d;
      out_q    <= out_d;
      evcnt_q  <= evcnt_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
    end
  end

  assign mmo_readdata = rdata_q;
  assign pio_out      = out_q[OUT_WIDTH-1:0];
  assign irq          = irq_q;

endmodule

// File: tb/tb_mmo_pio_bank.sv
// Directed bench for mmo_pio_bank with a short debounce window
// (DEB_CYCLES=4): input path, edge capture, irq, counter, outputs.
module tb_mmo_pio_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] rdata;
  logic [4:0]  pin;
  logic [7:0]  pout;
  logic        irq;

  int n_chk  = 0;
  int n_pass = 0;

  mmo_pio_bank #(
    .IN_WIDTH(5), .OUT_WIDTH(8), .ADDR_WIDTH(5),
    .DEB_CYCLES(4), .DEB_WIDTH(16)
  ) dut (
    .clk_clk(clk), .reset(rst),
    .mmo_address(addr), .mmo_writedata(wdata),
    .mmo_byteenable(be), .mmo_read(rd_en),
    .mmo_write(wr_en), .mmo_readdata(rdata),
    .pio_in(pin), .pio_out(pout), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d,
                    input logic [3:0] b);
    addr = a; wdata = d; be = b; wr_en = 1'b1;
    tick();
    wr_en = 1'b0; be = 4'h0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    addr = a; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    d = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1; addr = '0; wdata = '0; be = '0;
    rd_en = 1'b0; wr_en = 1'b0; pin = '0;
    repeat (3) tick();
    rst = 1'b0;
    n_chk++;
    if (rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", rdata);
    else n_pass++;
    n_chk++;
    if (pout !== 8'h0) $display("FAIL rst_pout got %h want 0", pout);
    else n_pass++;
    n_chk++;
    if (irq !== 1'b0) $display("FAIL rst_irq got %b want 0", irq);
    else n_pass++;
    rd(5'd7, d);
    n_chk++;
    if (d !== 32'hA505_0801) $display("FAIL id got %h want a5050801", d);
    else n_pass++;
    rd(5'd0, d);
    n_chk++;
    if (d !== 32'h0) $display("FAIL rst_data got %h want 0", d);
    else n_pass++;
  endtask

  task automatic test_rise_capture();
    logic [31:0] d;
    wr(5'd2, 32'h1, 4'hF);
    wr(5'd4, 32'h1, 4'hF);
    pin[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rd(5'd0, d);
      n_chk++;
      if (d !== 32'h0) $display("FAIL rise_wait%0d got %h want 0", k, d);
      else n_pass++;
    end
    rd(5'd0, d);
    n_chk++;
    if (d !== 32'h1) $display("FAIL rise_data got %h want 1", d);
    else n_pass++;
    rd(5'd3, d);
    n_chk++;
    if (d !== 32'h1) $display("FAIL rise_cap got %h want 1", d);
    else n_pass++;
    n_chk++;
    if (irq !== 1'b1) $display("FAIL rise_irq got %b want 1", irq);
    else n_pass++;
    rd(5'd6, d);
    n_chk++;
    if (d !== 32'h1) $display("FAIL rise_cnt got %h want 1", d);
    else n_pass++;
    wr(5'd3, 32'h1, 4'hF);
    tick();
    n_chk++;
    if (irq !== 1'b0) $display("FAIL w1c_irq got %b want 0", irq);
    else n_pass++;
    rd(5'd3, d);
    n_chk++;
    if (d !== 32'h0) $display("FAIL w1c_cap got %h want 0", d);
    else n_pass++;
  endtask

  task automatic test_bounce();
    logic [31:0] d;
    logic [1:0] lvl [4];
    int len [4];
    lvl = '{2'd1, 2'd0, 2'd1, 2'd0};
    len = '{3, 1, 3, 1};
    wr(5'd2, 32'h3, 4'hF);
    wr(5'd6, 32'h0, 4'hF);
    rd(5'd6, d);
    n_chk++;
    if (d !== 32'h0) $display("FAIL cnt_clear got %h want 0", d);
    else n_pass++;
    for (int p = 0; p < 4; p++) begin
      pin[1] = lvl[p][0];
      for (int k = 0; k < len[p]; k++) begin
        rd(5'd0, d);
        n_chk++;
        if (d !== 32'h1)
          $display("FAIL bounce_p%0d got %h want 1", p, d);
        else n_pass++;
      end
    end
    pin[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rd(5'd0, d);
      n_chk++;
      if (d !== 32'h1) $display("FAIL hold%0d got %h want 1", k, d);
      else n_pass++;
    end
    rd(5'd0, d);
    n_chk++;
    if (d !== 32'h3) $display("FAIL hold_data got %h want 3", d);
    else n_pass++;
    rd(5'd6, d);
    n_chk++;
    if (d !== 32'h1) $display("FAIL bounce_cnt got %h want 1", d);
    else n_pass++;
    rd(5'd3, d);
    n_chk++;
    if (d !== 32'h2) $display("FAIL bounce_cap got %h want 2", d);
    else n_pass++;
    n_chk++;
    if (irq !== 1'b0) $display("FAIL masked_irq got %b want 0", irq);
    else n_pass++;
    wr(5'd3, 32'h2, 4'hF);
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    wr(5'd2, 32'h0004_0000, 4'hF);
    pin[2] = 1'b1;
    repeat (8) tick();
    pin[2] = 1'b0;
    repeat (6) tick();
    wr(5'd3, 32'h4, 4'hF);
    rd(5'd3, d);
    n_chk++;
    if (d !== 32'h4) $display("FAIL set_wins got %h want 4", d);
    else n_pass++;
    rd(5'd6, d);
    n_chk++;
    if (d !== 32'h2) $display("FAIL fall_cnt got %h want 2", d);
    else n_pass++;
    wr(5'd3, 32'h4, 4'hF);
    rd(5'd3, d);
    n_chk++;
    if (d !== 32'h0) $display("FAIL cap_clr got %h want 0", d);
    else n_pass++;
    rd(5'd0, d);
    n_chk++;
    if (d !== 32'h3) $display("FAIL fall_data got %h want 3", d);
    else n_pass++;
  endtask

  task automatic test_regs();
    logic [31:0] d;
    wr(5'd5, 32'hFFFF_FFFF, 4'b0001);
    n_chk++;
    if (pout !== 8'hFF) $display("FAIL out_be0 got %h want ff", pout);
    else n_pass++;
    wr(5'd5, 32'h0000_AB00, 4'b0010);
    n_chk++;
    if (pout !== 8'hFF) $display("FAIL out_be1 got %h want ff", pout);
    else n_pass++;
    wr(5'd5, 32'h1234_5678, 4'b0001);
    n_chk++;
    if (pout !== 8'h78) $display("FAIL out_new got %h want 78", pout);
    else n_pass++;
    rd(5'd5, d);
    n_chk++;
    if (d !== 32'h78) $display("FAIL out_rd got %h want 78", d);
    else n_pass++;
    wr(5'd0, 32'hFFFF, 4'hF);
    rd(5'd0, d);
    n_chk++;
    if (d !== 32'h3) $display("FAIL ro_data got %h want 3", d);
    else n_pass++;
    rd(5'd9, d);
    n_chk++;
    if (d !== 32'h0) $display("FAIL unmapped got %h want 0", d);
    else n_pass++;
    wr(5'd2, 32'hFFFF_FFFF, 4'hF);
    rd(5'd2, d);
    n_chk++;
    if (d !== 32'h001F_001F) $display("FAIL edge_rd got %h want 001f001f", d);
    else n_pass++;
    wr(5'd2, 32'h0, 4'hF);
    addr = 5'd4; wdata = 32'h1F; be = 4'hF;
    rd_en = 1'b1; wr_en = 1'b1;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    n_chk++;
    if (rdata !== 32'h1) $display("FAIL rw_same got %h want 1", rdata);
    else n_pass++;
    rd(5'd4, d);
    n_chk++;
    if (d !== 32'h1F) $display("FAIL mask_rd got %h want 1f", d);
    else n_pass++;
    wr(5'd4, 32'h1, 4'hF);
  endtask

  task automatic test_counter();
    logic [31:0] d;
    force dut.evcnt_q = 32'hFFFF_FFFF;
    tick();
    release dut.evcnt_q;
    rd(5'd6, d);
    n_chk++;
    if (d !== 32'hFFFF_FFFF) $display("FAIL preload got %h want ffffffff", d);
    else n_pass++;
    wr(5'd2, 32'h0001_0000, 4'hF);
    pin[0] = 1'b0;
    repeat (7) tick();
    rd(5'd6, d);
    n_chk++;
    if (d !== 32'h0) $display("FAIL wrap got %h want 0", d);
    else n_pass++;
    n_chk++;
    if (irq !== 1'b1) $display("FAIL fall_irq got %b want 1", irq);
    else n_pass++;
    wr(5'd2, 32'h1, 4'hF);
    pin[0] = 1'b1;
    repeat (6) tick();
    wr(5'd6, 32'h0, 4'b0001);
    rd(5'd6, d);
    n_chk++;
    if (d !== 32'h1) $display("FAIL clr_ev got %h want 1", d);
    else n_pass++;
    wr(5'd6, 32'h0, 4'b0000);
    rd(5'd6, d);
    n_chk++;
    if (d !== 32'h1) $display("FAIL clr_nobe got %h want 1", d);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    pin[1] = 1'b0;
    repeat (3) tick();
    addr = 5'd7; rd_en = 1'b1;
    #3 rst = 1'b1;
    #1;
    n_chk++;
    if (pout !== 8'h0) $display("FAIL arst_pout got %h want 0", pout);
    else n_pass++;
    n_chk++;
    if (irq !== 1'b0) $display("FAIL arst_irq got %b want 0", irq);
    else n_pass++;
    tick();
    n_chk++;
    if (rdata !== 32'h0) $display("FAIL arst_rdata got %h want 0", rdata);
    else n_pass++;
    rd_en = 1'b0;
    rst = 1'b0;
    rd(5'd0, d);
    n_chk++;
    if (d !== 32'h0) $display("FAIL arst_data got %h want 0", d);
    else n_pass++;
    rd(5'd6, d);
    n_chk++;
    if (d !== 32'h0) $display("FAIL arst_cnt got %h want 0", d);
    else n_pass++;
    rd(5'd3, d);
    n_chk++;
    if (d !== 32'h0) $display("FAIL arst_cap got %h want 0", d);
    else n_pass++;
    rd(5'd2, d);
    n_chk++;
    if (d !== 32'h0) $display("FAIL arst_edge got %h want 0", d);
    else n_pass++;
    rd(5'd5, d);
    n_chk++;
    if (d !== 32'h0) $display("FAIL arst_out got %h want 0", d);
    else n_pass++;
    repeat (8) tick();
    rd(5'd0, d);
    n_chk++;
    if (d !== 32'h1) $display("FAIL post_data got %h want 1", d);
    else n_pass++;
    rd(5'd3, d);
    n_chk++;
    if (d !== 32'h0) $display("FAIL post_cap got %h want 0", d);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_rise_capture();
    test_bounce();
    test_set_wins();
    test_regs();
    test_counter();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
